// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and helpers for the SHA256 host-side controller.
package sha256_pkg;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int HASH_WORDS      = 8;
  localparam int WORD_W          = 32;
  localparam int DIGEST_W        = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_SOC      = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4,
    ST_WAIT_EOC = 3'd5,
    ST_READ     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Bit offset of hash word idx inside the digest (H0 lives in the top word).
  function automatic logic [7:0] hash_lsb(input logic [2:0] idx);
    return {3'(HASH_WORDS - 1) - idx, 5'd0};
  endfunction
endpackage

// File: rtl/sha256_host_ctrl_if.sv
// Message-word stream plus the core's soc/data/rd/eoc bus, bundled for the controller.
interface sha256_host_ctrl_if;
  import sha256_pkg::*;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] sha_data;
  logic              sha_soc;
  logic              sha_rd;
  logic              sha_eoc;
  logic [WORD_W-1:0] sha_hash_out;

  modport master (
    input  in_word, in_valid, sha_eoc, sha_hash_out,
    output in_ready, sha_data, sha_soc, sha_rd
  );
  modport slave (
    output in_word, in_valid, sha_eoc, sha_hash_out,
    input  in_ready, sha_data, sha_soc, sha_rd
  );
endinterface

// File: rtl/sha256_blk_buf.sv
// One 512-bit message block held as 16 words; written by fill index, read by send index.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] mem;

  // Data storage only: contents are always rewritten in FILL before SEND reads them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sha256_host_ctrl.sv
// Initiator for the SHA256 core: buffers blocks, plays soc/data/gap per block, then reads the digest.
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int COMPRESS_CYCLES = 48,
  parameter int RD_LATENCY      = 1,
  parameter int EOC_TIMEOUT     = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          n_blocks,
  sha256_host_ctrl_if.master  bus,
  output logic [DIGEST_W-1:0] digest,
  output logic                done,
  output logic                busy,
  output logic                err
);
  localparam int GAP_W = $clog2(COMPRESS_CYCLES) + 1;
  localparam int TMO_W = $clog2(EOC_TIMEOUT) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(COMPRESS_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EOC_TIMEOUT - 1);

  state_e              state, state_nx;
  logic [3:0]          word_cnt;
  logic [7:0]          blk_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [3:0]          rd_cnt;
  logic [WORD_W-1:0]   buf_rdata;
  logic                in_ready_c, soc_c, rd_c;
  logic [WORD_W-1:0]   data_c;
  logic                xfer, cap;
  logic [2:0]          cap_idx;
  logic [RD_LATENCY:0]      vld_pipe;
  logic [RD_LATENCY:0][2:0] idx_pipe;

  assign xfer = bus.in_valid & in_ready_c;

  sha256_blk_buf u_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (word_cnt),
    .wdata (bus.in_word),
    .raddr (word_cnt),
    .rdata (buf_rdata)
  );

  // Read-data valid/index pipeline: stage 0 is the rd strobe itself.
  if (RD_LATENCY == 0) begin : g_rd_nolat
    assign vld_pipe = rd_c;
    assign idx_pipe = rd_cnt[2:0];
  end else begin : g_rd_lat
    logic [RD_LATENCY-1:0]      vld_q;
    logic [RD_LATENCY-1:0][2:0] idx_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        idx_q <= '0;
      end else begin
        vld_q[0] <= rd_c;
        idx_q[0] <= rd_cnt[2:0];
        for (int i = 1; i < RD_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end
    assign vld_pipe = {vld_q, rd_c};
    assign idx_pipe = {idx_q, rd_cnt[2:0]};
  end

  assign cap     = vld_pipe[RD_LATENCY];
  assign cap_idx = idx_pipe[RD_LATENCY];

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    soc_c      = 1'b0;
    rd_c       = 1'b0;
    data_c     = '0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && n_blocks != 8'd0) state_nx = ST_FILL;
      end
      ST_FILL: begin
        in_ready_c = 1'b1;
        if (xfer && word_cnt == 4'd15) state_nx = ST_SOC;
      end
      ST_SOC: begin
        soc_c    = 1'b1;
        state_nx = ST_SEND;
      end
      ST_SEND: begin
        data_c = buf_rdata;
        if (word_cnt == 4'd15) state_nx = ST_GAP;
      end
      ST_GAP: begin
        // blk_cnt was already decremented when the last word went out.
        if (gap_cnt == GAP_LAST) state_nx = (blk_cnt != 8'd0) ? ST_FILL : ST_WAIT_EOC;
      end
      ST_WAIT_EOC: begin
        if (bus.sha_eoc)              state_nx = ST_READ;
        else if (tmo_cnt == TMO_LAST) state_nx = ST_IDLE;
      end
      ST_READ: begin
        rd_c = ~rd_cnt[3];
        if (cap && cap_idx == 3'(HASH_WORDS - 1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign bus.sha_soc  = soc_c;
  assign bus.sha_rd   = rd_c;
  assign bus.sha_data = data_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      blk_cnt  <= '0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      rd_cnt   <= '0;
      digest   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= 1'b0;

      if (state == ST_IDLE && start) begin
        if (n_blocks == 8'd0) begin
          err <= 1'b1;
        end else begin
          blk_cnt <= n_blocks;
          digest  <= '0;
        end
      end

      // Shared fill/send index; wraps 15->0 at the end of each phase.
      if (xfer || state == ST_SEND) word_cnt <= word_cnt + 4'd1;

      if (state == ST_SEND && word_cnt == 4'd15 && blk_cnt != 8'd0)
        blk_cnt <= blk_cnt - 8'd1;

      gap_cnt <= (state == ST_GAP && state_nx == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      tmo_cnt <= (state == ST_WAIT_EOC && state_nx == ST_WAIT_EOC) ? tmo_cnt + TMO_W'(1) : '0;

      if (state == ST_WAIT_EOC && !bus.sha_eoc && tmo_cnt == TMO_LAST) err <= 1'b1;

      if (state != ST_READ) rd_cnt <= '0;
      else if (rd_c)        rd_cnt <= rd_cnt + 4'd1;

      if (cap) digest[hash_lsb(cap_idx) +: WORD_W] <= bus.sha_hash_out;
    end
  end
endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Directed bench: controller against a behavioural SHA256 core model with protocol bookkeeping.
module tb_sha256_host_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   n_blocks;
  logic [255:0] digest;
  logic         done, busy, err;
  int           checks = 0;
  int           errors = 0;

  sha256_host_ctrl_if bus ();

  sha256_host_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_blocks(n_blocks), .bus(bus),
    .digest(digest), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Padded messages: "abc" at 0..15, the 448-bit two-block message at 16..47.
  logic [31:0] msg [0:47] = '{
    32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018,
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Core model and protocol bookkeeping, all sampled on the rising edge.
  int           cyc = 0;
  int           start_cyc, soc_last, soc_prev, data_first, data_last, err_cyc;
  int           soc_cnt = 0, rd_total = 0, xfer_cnt = 0, xfer_at_soc = 0, proto_err = 0;
  bit           hold_eoc = 1'b0;
  logic         rx_act = 1'b0;
  logic [3:0]   rx_cnt = '0;
  logic [2:0]   rd_idx = '0;
  int           eoc_dly = 0;
  logic [511:0] rx_buf, blk_tmp;
  logic [255:0] h_m = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rx_act <= 1'b0;
      bus.sha_eoc <= 1'b0;
      eoc_dly <= 0;
    end else begin
      if (start && !busy) begin
        h_m <= IV; rd_idx <= '0; rd_total <= 0; xfer_cnt <= 0; start_cyc <= cyc;
      end else if (bus.in_valid && bus.in_ready) begin
        xfer_cnt <= xfer_cnt + 1;
      end
      if (bus.sha_soc) begin
        if (rx_act) proto_err <= proto_err + 1;
        soc_cnt <= soc_cnt + 1; soc_prev <= soc_last; soc_last <= cyc; xfer_at_soc <= xfer_cnt;
        rx_act <= 1'b1; rx_cnt <= '0; bus.sha_eoc <= 1'b0; eoc_dly <= 0;
      end else if (rx_act) begin
        blk_tmp = rx_buf;
        blk_tmp[{4'd15 - rx_cnt, 5'd0} +: 32] = bus.sha_data;
        rx_buf <= blk_tmp;
        if (rx_cnt == 4'd0) data_first <= cyc;
        if (rx_cnt == 4'd15) begin
          rx_act <= 1'b0; data_last <= cyc; h_m <= sha_comp(h_m, blk_tmp); eoc_dly <= 10;
        end
        rx_cnt <= rx_cnt + 4'd1;
      end else if (eoc_dly != 0) begin
        eoc_dly <= eoc_dly - 1;
        if (eoc_dly == 1 && !hold_eoc) bus.sha_eoc <= 1'b1;
      end
      if (bus.sha_rd) begin
        bus.sha_hash_out <= h_m[{3'd7 - rd_idx, 5'd0} +: 32];
        rd_idx <= rd_idx + 3'd1; rd_total <= rd_total + 1;
      end
      if (err) err_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start at a negedge, then offer nwords words from msg[base..]; optional random valid gaps.
  task automatic run_msg(input int base, input int nwords, input logic [7:0] nb, input bit gaps);
    int n;
    bit stalled = 1'b0;
    start = 1'b1; n_blocks = nb;
    bus.in_valid = !gaps; bus.in_word = msg[base];
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) begin bus.in_valid = 1'b0; @(negedge clk); end
      bus.in_valid = 1'b1; bus.in_word = msg[base + k];
      n = 0;
      while (!bus.in_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) stalled = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("fill_no_stall", stalled, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int soc0, rd0;
    rst = 1'b1; start = 1'b0; n_blocks = '0;
    bus.in_valid = 1'b0; bus.in_word = '0; bus.sha_hash_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus.in_ready, bus.sha_soc, bus.sha_rd, done, busy, err, bus.sha_data}, '0);
    chk("rst_digest", digest, '0);
    rst = 1'b0;
    @(negedge clk);

    // 1: "abc", continuous valid
    run_msg(0, 16, 8'd1, 1'b0);
    wait_done();
    chk("c1_digest", digest, DIG_ABC);
    chk("c1_soc_lat", soc_last - start_cyc, 17);
    chk("c1_data_first", data_first - start_cyc, 18);
    chk("c1_data_last", data_last - start_cyc, 33);
    chk("c1_rd_count", rd_total, 8);
    chk("c1_digest_hold", digest, DIG_ABC);

    // 2: two blocks back-to-back
    soc0 = soc_cnt;
    run_msg(16, 32, 8'd2, 1'b0);
    wait_done();
    chk("c2_digest", digest, DIG_2B);
    chk("c2_soc_count", soc_cnt - soc0, 2);
    chk("c2_soc_spacing", soc_last - soc_prev, 81);

    // 3: random valid gaps during FILL
    run_msg(0, 16, 8'd1, 1'b1);
    wait_done();
    chk("c3_digest", digest, DIG_ABC);
    chk("c3_soc_after_16", xfer_at_soc, 16);
    chk("c3_send_contig", data_last - soc_last, 16);
    chk("c3_proto", proto_err, 0);

    // 4a: n_blocks == 0
    soc0 = soc_cnt;
    start = 1'b1; n_blocks = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("c4_err_pulse", err, 1'b1);
    chk("c4_busy_low", busy, 1'b0);
    @(negedge clk);
    chk("c4_err_single", err, 1'b0);
    repeat (60) @(negedge clk);
    chk("c4_no_soc", soc_cnt - soc0, 0);
    chk("c4_digest_kept", digest, DIG_ABC);

    // 4b: start while busy is ignored
    run_msg(0, 16, 8'd1, 1'b0);
    start = 1'b1; n_blocks = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("c4_busy_start_digest", digest, DIG_ABC);
    chk("c4_busy_start_socs", soc_cnt - soc0, 1);

    // 5: eoc withheld -> timeout 256 cycles after WAIT_EOC entry (start+82)
    hold_eoc = 1'b1;
    run_msg(0, 16, 8'd1, 1'b0);
    begin
      int n = 0;
      while (!err && n < 1000) begin @(negedge clk); n++; end
    end
    chk("c5_err_seen", err, 1'b1);
    chk("c5_busy_low", busy, 1'b0);
    @(negedge clk);
    chk("c5_err_time", err_cyc - start_cyc, 338);
    chk("c5_no_rd", rd_total, 0);
    hold_eoc = 1'b0;

    // 6: reset during SEND word 7 (start+25)
    soc0 = soc_cnt;
    run_msg(0, 16, 8'd1, 1'b0);
    repeat (8) @(negedge clk);
    chk("c6_in_send", data_first - start_cyc, 18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c6_rst_ctl", {bus.in_ready, bus.sha_soc, bus.sha_rd, done, busy, err, bus.sha_data}, '0);
    chk("c6_rst_digest", digest, '0);
    rd0 = rd_total;
    repeat (100) @(negedge clk);
    chk("c6_no_soc", soc_cnt - soc0, 1);
    chk("c6_no_rd", rd_total - rd0, 0);
    run_msg(0, 16, 8'd1, 1'b0);
    wait_done();
    chk("c6_restart_digest", digest, DIG_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
